// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory controller
// Provides access-size and FSM state enums, requester ids, default memory size
// and a helper returning the byte count of an access size.
package dmem_pkg;
    typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10} size_e;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG = 1'b1;
    localparam int MEM_BYTES_DEF = 1024;
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return (size == SIZE_B) ? 3'd1 : (size == SIZE_H) ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte/half lane merge for stores and lane extract/extend for loads
// Ports: word (memory word), wdata (right-justified store data), size, offset (addr[1:0]),
// is_unsigned (zero-extend loads), merged (word with lanes replaced), loaded (aligned, extended result).
module dmem_lane_align import dmem_pkg::*; (
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] loaded
);
    logic [31:0] mask;
    logic [31:0] shifted;
    always_comb begin
        mask    = ((size == SIZE_B) ? 32'h0000_00FF : (size == SIZE_H) ? 32'h0000_FFFF : 32'hFFFF_FFFF) << {offset, 3'b000};
        merged  = (word & ~mask) | ((wdata << {offset, 3'b000}) & mask);
        shifted = word >> {offset, 3'b000};
        loaded  = (size == SIZE_B) ? {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]}
                : (size == SIZE_H) ? {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]}
                : shifted;
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-requester round-robin data-memory controller with RMW stores and load alignment
// Ports: clock, reset_n (async, active-low); per requester k: req_valid/ready/addr/wdata/we/size/unsigned,
// rsp_valid/rdata/err; memory side: mem_addr (word aligned), mem_wdata, mem_wr_en, mem_rdata (registered read).
module dmem_ctrl import dmem_pkg::*; #(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    input  logic [1:0]       req_we,
    input  logic [1:0][1:0]  req_size,
    input  logic [1:0]       req_unsigned,
    output logic [1:0]       rsp_valid,
    output logic [1:0][31:0] rsp_rdata,
    output logic [1:0]       rsp_err,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_wr_en,
    input  logic [31:0]      mem_rdata
);
    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        gnt, accept, chk_err, in_resp;
    logic [31:0] sel_addr, merged, loaded, load_data;
    logic [1:0]  sel_size;

    dmem_lane_align u_align (
        .word        (mem_rdata),
        .wdata       (wdata_q),
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (uns_q),
        .merged      (merged),
        .loaded      (loaded)
    );

    // reset_n gates acceptance so req_ready is low while reset is held
    always_comb begin
        gnt       = (req_valid[REQ_CORE] && req_valid[REQ_DBG]) ? ptr_q : (req_valid[REQ_DBG] ? REQ_DBG : REQ_CORE);
        accept    = reset_n && (state_q == IDLE) && (|req_valid);
        req_ready = accept ? (2'b01 << gnt) : 2'b00;
        sel_addr  = req_addr[gnt];
        sel_size  = req_size[gnt];
        // 33-bit sum so addresses near 2^32 cannot wrap into range
        chk_err   = (sel_size == 2'b11) || (sel_size == SIZE_H && sel_addr[0])
                 || (sel_size == SIZE_W && sel_addr[1:0] != 2'b00)
                 || (({1'b0, sel_addr} + {30'd0, size_bytes(sel_size)}) > 33'(MEM_BYTES));
        ptr_d     = accept ? ~gnt : ptr_q;
        owner_d   = accept ? gnt : owner_q;
        addr_d    = accept ? sel_addr : addr_q;
        wdata_d   = accept ? req_wdata[gnt] : wdata_q;
        we_d      = accept ? req_we[gnt] : we_q;
        size_d    = accept ? sel_size : size_q;
        uns_d     = accept ? req_unsigned[gnt] : uns_q;
        err_d     = accept ? chk_err : err_q;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (chk_err) state_d = RESP;
                    else if (req_we[gnt] && sel_size == SIZE_W) state_d = WRITE;
                    else state_d = READ;
                end
            end
            READ: begin
                if (we_q) state_d = WRITE;
                else state_d = RESP;
            end
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_resp      = state_q == RESP;
        mem_wr_en    = state_q == WRITE;
        mem_addr     = {addr_q[31:2], 2'b00};
        mem_wdata    = mem_wr_en ? merged : 32'd0;
        rsp_valid    = in_resp ? (2'b01 << owner_q) : 2'b00;
        rsp_err      = (in_resp && err_q) ? (2'b01 << owner_q) : 2'b00;
        load_data    = (in_resp && !we_q && !err_q) ? loaded : 32'd0;
        rsp_rdata[0] = owner_q ? 32'd0 : load_data;
        rsp_rdata[1] = owner_q ? load_data : 32'd0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= REQ_CORE;
            owner_q <= REQ_CORE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench with byte-level reference model and per-cycle output comparison
module tb_dmem_ctrl;
    localparam int MB = 1024;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic        va [2];
    logic [31:0] ad [2];
    logic [31:0] wdv [2];
    logic        wev [2];
    logic [1:0]  szv [2];
    logic        unv [2];

    logic [1:0]       req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_err;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0][1:0]  req_size;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic             mem_wr_en;

    logic [7:0] mem [MB];
    logic [7:0] ref_mem [MB];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rsp_cnt [2] = '{0, 0};
    int gq [$];

    assign req_valid    = {va[1], va[0]};
    assign req_addr     = {ad[1], ad[0]};
    assign req_wdata    = {wdv[1], wdv[0]};
    assign req_we       = {wev[1], wev[0]};
    assign req_size     = {szv[1], szv[0]};
    assign req_unsigned = {unv[1], unv[0]};

    dmem_ctrl #(.MEM_BYTES(MB)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // simulation memory: registered read on rising edge, write on falling edge
    always @(posedge clock)
        mem_rdata <= (mem_addr < MB) ? {mem[int'(mem_addr[9:0]) + 3], mem[int'(mem_addr[9:0]) + 2],
                                        mem[int'(mem_addr[9:0]) + 1], mem[int'(mem_addr[9:0])]} : 32'd0;
    always @(negedge clock)
        if (mem_wr_en && mem_addr < MB)
            for (int i = 0; i < 4; i++) mem[int'(mem_addr[9:0]) + i] = mem_wdata[8*i +: 8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: one transaction in flight, byte-addressed memory image
    logic        pend = 1'b0;
    int          m_ptr = 0;
    int          win, p_owner, p_due, p_wrcyc, p_addr, p_n, base;
    logic        p_err, p_wr;
    logic [31:0] p_rd, p_wd, ma;
    logic [1:0]  ms;
    logic [1:0]  e_ready, e_valid, e_err;
    logic [31:0] e_rd0, e_rd1, e_wd;
    logic        e_wr;

    always @(negedge clock) begin
        rsp_cnt[0] += int'(rsp_valid[0]);
        rsp_cnt[1] += int'(rsp_valid[1]);
        wr_cnt += int'(mem_wr_en);
        if (req_ready[0]) gq.push_back(0);
        if (req_ready[1]) gq.push_back(1);
        if (!reset_n) begin
            chk("rst_ready", {30'd0, req_ready}, 0);
            chk("rst_rsp_valid", {30'd0, rsp_valid}, 0);
            chk("rst_rsp_err", {30'd0, rsp_err}, 0);
            chk("rst_rdata0", rsp_rdata[0], 0);
            chk("rst_rdata1", rsp_rdata[1], 0);
            chk("rst_wr_en", {31'd0, mem_wr_en}, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            pend = 1'b0;
            m_ptr = 0;
        end else begin
            e_ready = 2'b00; e_valid = 2'b00; e_err = 2'b00;
            e_rd0 = 0; e_rd1 = 0; e_wr = 1'b0; e_wd = 0;
            win = (va[0] && va[1]) ? m_ptr : (va[1] ? 1 : 0);
            if (!(pend && cyc <= p_due) && (va[0] || va[1])) e_ready[win] = 1'b1;
            if (pend && cyc == p_due) begin
                e_valid[p_owner] = 1'b1;
                e_err[p_owner] = p_err;
                if (p_owner == 1) e_rd1 = p_rd; else e_rd0 = p_rd;
            end
            if (pend && p_wr && cyc == p_wrcyc) begin
                for (int i = 0; i < p_n; i++) ref_mem[p_addr + i] = p_wd[8*i +: 8];
                base = p_addr & ~3;
                e_wr = 1'b1;
                e_wd = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
                chk("m_mem_addr", mem_addr, base);
                chk("m_mem_wdata", mem_wdata, e_wd);
            end
            chk("m_ready", {30'd0, req_ready}, {30'd0, e_ready});
            chk("m_rsp_valid", {30'd0, rsp_valid}, {30'd0, e_valid});
            chk("m_rsp_err", {30'd0, rsp_err}, {30'd0, e_err});
            chk("m_rdata0", rsp_rdata[0], e_rd0);
            chk("m_rdata1", rsp_rdata[1], e_rd1);
            chk("m_wr_en", {31'd0, mem_wr_en}, {31'd0, e_wr});
            if (pend && cyc == p_due) pend = 1'b0;
            if (e_ready != 2'b00) begin
                ma = ad[win];
                ms = szv[win];
                p_n = (ms == 2'd0) ? 1 : (ms == 2'd1) ? 2 : 4;
                p_err = (ms == 2'd3) || (ms == 2'd1 && ma[0]) || (ms == 2'd2 && ma[1:0] != 2'b00)
                     || (longint'(ma) + longint'(p_n) > longint'(MB));
                p_rd = 0;
                if (!p_err && !wev[win]) begin
                    for (int i = 0; i < p_n; i++) p_rd[8*i +: 8] = ref_mem[int'(ma[9:0]) + i];
                    if (!unv[win] && p_n < 4 && p_rd[8*p_n - 1]) p_rd = p_rd | (32'hFFFF_FFFF << (8 * p_n));
                end
                p_due = cyc + (p_err ? 1 : (!wev[win] || ms == 2'd2) ? 2 : 3);
                p_wr = !p_err && wev[win];
                p_wrcyc = cyc + ((ms == 2'd2) ? 1 : 2);
                p_addr = int'(ma[9:0]);
                p_wd = wdv[win];
                p_owner = win;
                pend = 1'b1;
                m_ptr = 1 - win;
            end
        end
    end

    task automatic issue(input int k, input logic [31:0] addr, input logic [31:0] wd, input logic we,
                         input logic [1:0] sz, input logic uns, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input int exp_wr, input string tag);
        int a, w0;
        logic got;
        @(posedge clock); #1;
        va[k] = 1'b1; ad[k] = addr; wdv[k] = wd; wev[k] = we; szv[k] = sz; unv[k] = uns;
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clock);
            got = req_ready[k];
        end
        a = cyc;
        w0 = wr_cnt;
        @(posedge clock); #1;
        va[k] = 1'b0;
        chk({tag, "_accept"}, {31'd0, got}, 1);
        if (!got) return;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clock);
            got = rsp_valid[k];
        end
        chk({tag, "_rsp_seen"}, {31'd0, got}, 1);
        if (!got) return;
        chk({tag, "_rdata"}, rsp_rdata[k], exp_rd);
        chk({tag, "_err"}, {31'd0, rsp_err[k]}, {31'd0, exp_err});
        chk({tag, "_latency"}, cyc - a, exp_lat);
        chk({tag, "_wr_pulses"}, wr_cnt - w0, exp_wr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int g0, r0, w0, diff;
        logic got;
        for (int i = 0; i < MB; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        for (int k = 0; k < 2; k++) begin
            va[k] = 1'b0; ad[k] = 0; wdv[k] = 0; wev[k] = 1'b0; szv[k] = 2'd0; unv[k] = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1;
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;

        g0 = gq.size();
        fork
            begin
                issue(0, 32'h40, 32'h1111_1111, 1, 2'd2, 0, 0, 0, 2, 1, "arb_r0a");
                issue(0, 32'h48, 32'h2222_2222, 1, 2'd2, 0, 0, 0, 2, 1, "arb_r0b");
            end
            begin
                issue(1, 32'h44, 32'hAAAA_AAAA, 1, 2'd2, 0, 0, 0, 2, 1, "arb_r1a");
                issue(1, 32'h4C, 32'hBBBB_BBBB, 1, 2'd2, 0, 0, 0, 2, 1, "arb_r1b");
            end
        join
        chk("arb_count", gq.size() - g0, 4);
        if (gq.size() - g0 >= 4) begin
            chk("arb_g0", gq[g0], 0);
            chk("arb_g1", gq[g0 + 1], 1);
            chk("arb_g2", gq[g0 + 2], 0);
            chk("arb_g3", gq[g0 + 3], 1);
        end
        issue(1, 32'h40, 0, 0, 2'd2, 0, 32'h1111_1111, 0, 2, 0, "r1_reads_r0");
        issue(1, 32'h48, 0, 0, 2'd2, 0, 32'h2222_2222, 0, 2, 0, "r1_reads_r0b");
        issue(0, 32'h44, 0, 0, 2'd2, 0, 32'hAAAA_AAAA, 0, 2, 0, "r0_reads_r1");
        issue(0, 32'h4C, 0, 0, 2'd2, 0, 32'hBBBB_BBBB, 0, 2, 0, "r0_reads_r1b");

        issue(0, 32'h10, 32'hDEAD_BEEF, 1, 2'd2, 0, 0, 0, 2, 1, "sw");
        issue(0, 32'h10, 0, 0, 2'd2, 0, 32'hDEAD_BEEF, 0, 2, 0, "lw");
        issue(0, 32'h11, 32'hFFFF_FF5A, 1, 2'd0, 0, 0, 0, 3, 1, "sb");
        issue(0, 32'h10, 0, 0, 2'd2, 0, 32'hDEAD_5AEF, 0, 2, 0, "lw_after_sb");
        issue(0, 32'h12, 0, 0, 2'd1, 0, 32'hFFFF_DEAD, 0, 2, 0, "lh");
        issue(0, 32'h12, 0, 0, 2'd1, 1, 32'h0000_DEAD, 0, 2, 0, "lhu");
        issue(0, 32'h13, 0, 0, 2'd0, 0, 32'hFFFF_FFDE, 0, 2, 0, "lb");
        issue(0, 32'h13, 0, 0, 2'd0, 1, 32'h0000_00DE, 0, 2, 0, "lbu");
        issue(0, 32'h11, 0, 0, 2'd0, 0, 32'h0000_005A, 0, 2, 0, "lb_pos");
        issue(1, 32'h12, 32'hABCD_1234, 1, 2'd1, 0, 0, 0, 3, 1, "sh");
        issue(1, 32'h10, 0, 0, 2'd2, 0, 32'h1234_5AEF, 0, 2, 0, "lw_after_sh");

        issue(0, 32'h12, 0, 0, 2'd2, 0, 0, 1, 1, 0, "err_lw_mis");
        issue(0, 32'h11, 32'h5555, 1, 2'd1, 0, 0, 1, 1, 0, "err_sh_mis");
        issue(0, 32'h10, 0, 0, 2'd3, 0, 0, 1, 1, 0, "err_size");
        issue(0, 32'h400, 0, 0, 2'd2, 0, 0, 1, 1, 0, "err_range");
        issue(1, 32'h400, 32'h99, 1, 2'd2, 0, 0, 1, 1, 0, "err_sw_range");
        issue(0, 32'hFFFF_FFFC, 0, 0, 2'd2, 0, 0, 1, 1, 0, "err_wrap");
        issue(0, 32'h3FC, 0, 0, 2'd2, 0, 0, 0, 2, 0, "lw_top");
        issue(0, 32'h3FF, 32'h77, 1, 2'd0, 0, 0, 0, 3, 1, "sb_top");
        issue(0, 32'h3FC, 0, 0, 2'd2, 0, 32'h7700_0000, 0, 2, 0, "lw_top2");
        issue(1, 32'h3FF, 0, 0, 2'd0, 0, 32'h0000_0077, 0, 2, 0, "lb_top");
        issue(0, 32'h10, 32'h0000_0000, 1, 2'd2, 0, 0, 0, 2, 1, "sw_r0_last");

        @(posedge clock); #1;
        va[0] = 1'b1; ad[0] = 32'h20; wdv[0] = 32'h1234_5678; wev[0] = 1'b1; szv[0] = 2'd2; unv[0] = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clock);
            got = req_ready[0];
        end
        chk("rst_op_accept", {31'd0, got}, 1);
        r0 = rsp_cnt[0];
        w0 = wr_cnt;
        @(posedge clock); #1;
        va[0] = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("rst_op_no_rsp", rsp_cnt[0] - r0, 0);
        chk("rst_op_no_write", wr_cnt - w0, 0);
        chk("rst_op_wr_en_low", {31'd0, mem_wr_en}, 0);

        g0 = gq.size();
        fork
            issue(0, 32'h20, 0, 0, 2'd2, 0, 32'h0, 0, 2, 0, "post_rst_r0");
            issue(1, 32'h20, 0, 0, 2'd2, 0, 32'h0, 0, 2, 0, "post_rst_r1");
        join
        chk("post_rst_count", gq.size() - g0, 2);
        if (gq.size() - g0 >= 2) begin
            chk("post_rst_first", gq[g0], 0);
            chk("post_rst_second", gq[g0 + 1], 1);
        end

        repeat (2) @(posedge clock);
        diff = 0;
        for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) diff++;
        chk("mem_image", diff, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller between two requesters (requester 0 = core load/store unit, requester 1 = debug/DMA port) and the single-ported, byte-addressed simulation data memory. It arbitrates round-robin, sequences each access to match the memory's timing (write on falling edge, registered read on rising edge), performs read-modify-write for byte and halfword stores, and aligns and extends load data. It also rejects misaligned and out-of-range accesses.

## Interface
- `MEM_BYTES`, 1024: memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid[k]` in 1 (k=0,1): request present; the requester holds the request and its payload stable until `req_ready[k]`.
- `req_ready[k]` out 1: request accepted this cycle.
- `req_addr[k]` in 32: byte address.
- `req_wdata[k]` in 32: store data, right-justified.
- `req_we[k]` in 1: 1 = store, 0 = load.
- `req_size[k]` in 2: 00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- `req_unsigned[k]` in 1: load zero-extends when 1, sign-extends when 0.
- `rsp_valid[k]` out 1: one-cycle completion pulse to the owning requester.
- `rsp_rdata[k]` out 32: load result; 0 for stores, errors and when `rsp_valid[k]`=0.
- `rsp_err[k]` out 1: qualified by `rsp_valid[k]`; set for misaligned, out-of-range or reserved-size accesses.
- `mem_addr` out 32: word-aligned address to memory, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: full word to memory.
- `mem_wr_en` out 1: memory write enable.
- `mem_rdata` in 32: memory read data; it reflects `mem_addr` as of the previous rising edge.

## Operation
- States: IDLE, READ, WRITE, RESP.
- **Acceptance:** requests are accepted only in IDLE. `req_ready[k]` is combinational: it is high in IDLE when requester k holds the grant and `req_valid[k]`=1. On acceptance the controller latches addr, wdata, we, size, unsigned and the owner id.
- **Arbitration:** round-robin with a 1-bit priority pointer; reset value favours requester 0. When both are valid, the pointer side wins. After any grant the pointer moves to the other requester. A lone valid requester always wins.
- **Checks at accept:** error if size=11, half with addr[0]=1, word with addr[1:0]≠00, or addr+bytes>MEM_BYTES.
- **Transitions from IDLE:**
  - Error: RESP with `rsp_err`=1; memory is not touched.
  - Load: READ.
  - Word store: WRITE.
  - Byte or half store: READ.
- **READ:** drives `mem_addr`. Next state is RESP for a load, WRITE for a store.
- **WRITE:**
  - Asserts `mem_wr_en` for exactly one cycle. The memory commits on the falling edge within this cycle.
  - `mem_wdata` = `mem_rdata` with the addressed byte or half lane(s) replaced by the low bits of wdata, shifted by addr[1:0]. For a word store, `mem_wdata` = wdata.
  - Next state is RESP.
- **RESP:**
  - `mem_addr` is held at the access address, so `mem_rdata` stays stable.
  - `rsp_rdata` = lane at addr[1:0], zero- or sign-extended. For a word, the lane is the whole word.
  - `rsp_valid` is high for one cycle to the owner only. Next state is IDLE.
- `mem_addr` is held from acceptance through RESP and keeps its last value in IDLE.

## Timing
- Latency from the accept cycle (cycle 0) to the `rsp_valid` cycle:
  - Error: 1.
  - Load: 2.
  - Word store: 2.
  - Byte or half store: 3.
- No accept during RESP; the next accept is earliest in the cycle after RESP.
- Reset values: state IDLE, pointer 0, all `req_ready`/`rsp_valid`/`rsp_err` = 0, `rsp_rdata` = 0, `mem_wr_en` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Reset asserted mid-operation:
  - Outputs drop asynchronously and the operation is discarded; no response is issued.
  - A write whose falling edge follows reset assertion is suppressed.
- Simultaneous events:
  - `req_valid` arriving while the controller is busy waits with `req_ready`=0.
  - Both requesters valid in IDLE: exactly one `req_ready` is high.

## Structure
- Package `dmem_pkg` holds:
  - size enum (`SIZE_B`, `SIZE_H`, `SIZE_W`);
  - state enum;
  - requester id constants;
  - `MEM_BYTES` default.
- Sub-module `dmem_lane_align` is purely combinational and contains:
  - store merge (old word, wdata, size, offset → new word);
  - load extract (word, size, offset, unsigned → result).
- FSM, arbiter and request latch sit in `dmem_ctrl`, which instantiates `dmem_lane_align` once.

## Test plan
- **Word store then load (r0):** SW 0xDEADBEEF @0x10 → `rsp_valid[0]` 2 cycles after accept. LW @0x10 → 0xDEADBEEF, `rsp_err`=0.
- **Byte RMW (r0):** SB 0x5A @0x11 → exactly one `mem_wr_en` pulse, in cycle 2 after accept. Following LW @0x10 → 0xDEAD5AEF.
- **Extension:** LH @0x12 → 0xFFFFDEAD. LHU @0x12 → 0x0000DEAD. LB @0x13 → 0xFFFFFFDE. LBU @0x13 → 0x000000DE.
- **Errors:** LW @0x12, SH @0x11, size=11, LW @0x400 → each gives `rsp_err`=1 one cycle after accept, `rsp_rdata`=0, no `mem_wr_en`. LW @0x3FC → no error.
- **Arbitration:** both valid continuously → grants alternate 0,1,0,1. Responses go only to the owner. Each requester's stores are observable in memory.
- **Reset mid-op:** assert `reset_n`=0 during WRITE of SW 0x12345678 @0x20 → no `rsp_valid`. After release, `mem_wr_en`=0 and the pointer favours r0.
